return_addr_stack: RTL
======================

RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; ports SHALL be clk and rst_n.
REQ-002 The block SHALL have parameter DEPTH, default 10, meaning the number of 32-bit return-address entries.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h00000058, meaning the byte address of entry 0.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- jal_signal  in  1  push request; JAL is retiring this cycle
- ret_addr_in  in  32  return address (PC+4) to push
- js_signal  in  1  pop request; JS is retiring this cycle
- ret_addr_out  out  32  popped return address, registered
- ret_valid  out  1  one-cycle pulse; ret_addr_out holds a valid pop result
- top_stack  out  32  byte address of the current top entry
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow_err  out  1  sticky; a push was attempted while full
- underflow_err  out  1  sticky; a pop was attempted while empty

Function
REQ-005 Storage SHALL be DEPTH x 32-bit registers, plus a count register of width clog2(DEPTH+1).
REQ-006 Entry k SHALL correspond to byte address BASE_ADDR + 4*k; with the defaults, the range is 0x58..0x7C.
REQ-007 top_stack SHALL be BASE_ADDR + 4*(count-1) when count > 0, and BASE_ADDR when count == 0; it is combinational from count.
REQ-008 A push SHALL occur when jal_signal=1 and full=0, and SHALL do the following at the clock edge:
- write ret_addr_in into entry[count];
- increment count.
REQ-009 A pop SHALL occur when js_signal=1, jal_signal=0 and empty=0, and SHALL do the following at the clock edge:
- load entry[count-1] into ret_addr_out;
- assert ret_valid on the following cycle;
- decrement count.
- Pop latency: request cycle N -> data valid in cycle N+1.
REQ-010 If jal_signal and js_signal are both 1 in the same cycle, the push SHALL take priority and the pop SHALL be dropped: no ret_valid, no count decrement, no error.
REQ-011 A push while full SHALL be ignored, leaving storage and count unchanged, and SHALL set overflow_err.
REQ-012 A pop (with jal_signal=0) while empty SHALL be ignored and SHALL set underflow_err; ret_valid SHALL stay 0 and ret_addr_out SHALL hold its value.
REQ-013 ret_valid SHALL be high for exactly one cycle per accepted pop; ret_addr_out SHALL hold its last value when ret_valid=0.
REQ-014 Back-to-back pops on consecutive cycles SHALL each be accepted and SHALL return entries in LIFO order.
REQ-015 When push and pop are never simultaneous, count SHALL stay within 0..DEPTH; no wrap-around SHALL occur.
REQ-016 overflow_err and underflow_err SHALL clear only on reset.
REQ-017 Entry contents SHALL NOT be cleared by pops; stale data is don't-care.

Reset
REQ-018 When rst_n=0 at a rising edge, the block SHALL reset as follows:
- count=0;
- ret_addr_out=32'h0;
- ret_valid=0;
- overflow_err=0;
- underflow_err=0.
- After reset: top_stack=32'h00000058, empty=1, full=0.
REQ-019 Entry storage SHALL NOT require reset.
REQ-020 Reset SHALL override any same-cycle jal_signal or js_signal; a pop in the reset cycle SHALL produce no ret_valid.
REQ-021 Reset asserted in the cycle after an accepted pop SHALL force ret_valid=0 at that edge.

Verification
REQ-022 Reset, then push 0x00400010 -> top_stack=0x58, empty=0; then pop -> next cycle ret_valid=1 and ret_addr_out=0x00400010, empty=1.
REQ-023 Push 0x100, 0x200, 0x300 on consecutive cycles, then three consecutive pops -> ret_addr_out = 0x300, 0x200, 0x100 on three consecutive cycles with ret_valid=1 throughout.
REQ-024 Push 10 values -> full=1 and top_stack=0x7C; an 11th push -> count unchanged, overflow_err=1; then pop -> returns the 10th value.
REQ-025 Pop from empty after reset -> ret_valid stays 0, underflow_err=1, top_stack=0x58.
REQ-026 With count=2, assert jal_signal and js_signal together with ret_addr_in=0xABC -> count=3, top_stack=0x60, no ret_valid; then pop -> 0xABC.
REQ-027 With count=5 and errors set, assert rst_n=0 for one cycle -> count=0, errors=0, ret_valid=0, top_stack=0x58.

Source files
------------

// File: rtl/return_addr_stack.sv
// Return-address stack for JAL/JS call/return tracking.
// Entries live at byte addresses BASE_ADDR + 4*k. top_stack reports the
// address of the most recently pushed entry, or BASE_ADDR when empty.
//
// Request semantics: jal_signal and js_signal are single-cycle retire
// strobes with no back-pressure. A push is accepted when jal_signal=1 and
// the stack is not full. A pop is accepted when js_signal=1, jal_signal=0
// and the stack is not empty. A push wins over a same-cycle pop, and the
// pop is then dropped silently. An accepted pop returns its data through
// ret_addr_out with a one-cycle ret_valid pulse on the following cycle.
// Rejected requests set the sticky overflow_err or underflow_err flag.
module return_addr_stack #(
  parameter int          DEPTH     = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0058
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jal_signal,
  input  logic [31:0] ret_addr_in,
  input  logic        js_signal,
  output logic [31:0] ret_addr_out,
  output logic        ret_valid,
  output logic [31:0] top_stack,
  output logic        full,
  output logic        empty,
  output logic        overflow_err,
  output logic        underflow_err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   entry [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] top_idx;
  logic [31:0]   count_ext;
  logic          push_fire;
  logic          pop_fire;
  logic          push_rej;
  logic          pop_rej;

  // Request decode, occupancy flags and top-entry address.
  always_comb begin
    full      = (count == CW'(DEPTH));
    empty     = (count == '0);
    push_fire = jal_signal && !full;
    push_rej  = jal_signal && full;
    pop_fire  = js_signal && !jal_signal && !empty;
    pop_rej   = js_signal && !jal_signal && empty;
    top_idx   = count - CW'(1);
    count_ext = 32'(count);
    top_stack = BASE_ADDR;
    if (!empty) begin
      top_stack = BASE_ADDR + ((count_ext - 32'd1) << 2);
    end
  end

  // Entry storage; no reset, stale data above the top is don't-care.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      entry[count] <= ret_addr_in;
    end
  end

  // Occupancy count, pop result register and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count         <= '0;
      ret_addr_out  <= 32'h0;
      ret_valid     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      ret_valid <= pop_fire;
      if (push_fire) begin
        count <= count + CW'(1);
      end else if (pop_fire) begin
        count        <= top_idx;
        ret_addr_out <= entry[top_idx];
      end
      if (push_rej) begin
        overflow_err <= 1'b1;
      end
      if (pop_rej) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule
